each_pang_to_blk_packer: RTL
============================

Name: each_pang_to_blk_packer

Overview:
- Transmit-side counterpart of the per-pang sub-block extractor.
- Accepts a stream of sub-blocks, one per cycle, and packs them into a 16-slot block at slot positions starting from a shift offset.
- Double-buffers the block in two banks (ping/pang) and presents each finished block with a descriptor: need_full, need_pang_start_inc, need_pang_end_inc.
- The downstream sixteen-to-one selection path consumes these descriptors.

Parameters:
- SUB_BLK_BIT, 8, width of one sub-block.
- SFT_BIT, 4, width of the slot index and shift. Fixed at 4, which means 16 slots.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sub_blki  input  SUB_BLK_BIT  incoming sub-block.
- sub_valid  input  1  sub_blki is valid this cycle.
- sub_ready  output  1  packer can accept a sub-block this cycle.
- start_sft  input  SFT_BIT  first slot of a new block; sampled on the first accept into an EMPTY bank.
- flush  input  1  single-cycle pulse; closes the partially filled bank.
- blko  output  16*SUB_BLK_BIT  packed block; slot k occupies bits [k*SUB_BLK_BIT +: SUB_BLK_BIT].
- blk_valid  output  1  blko and the descriptor outputs are valid.
- blk_ready  input  1  consumer takes the block.
- need_full  output  1  all 16 slots were written (start 0, end 15).
- need_pang_start_inc  output  SFT_BIT  first written slot.
- need_pang_end_inc  output  SFT_BIT  last written slot.

Behaviour:
- Reset (synchronous, active-high) is applied on any cycle, including mid-block. It forces:
  - both banks to EMPTY;
  - fbank = 0, obank = 0, wr_ptr = 0;
  - blko = 0, blk_valid = 0, need_full = 0, need_pang_start_inc = 0, need_pang_end_inc = 0;
  - sub_ready = 1 on the first cycle after reset.
  Any partial block is discarded.
- Per-bank state is EMPTY, FILLING or FULL. Each bank also holds 16 slot registers, start and end.
  - fbank is the bank being filled.
  - obank is the bank being presented.
- sub_ready = (state[fbank] != FULL). It is combinational from registered state only.
- Accept condition: sub_valid && sub_ready.
  - If state[fbank] is EMPTY: write the slot at start_sft, set start = start_sft, wr_ptr = start_sft + 1 (mod 16), and state becomes FILLING.
  - If state[fbank] is FILLING: write the slot at wr_ptr, then wr_ptr = wr_ptr + 1 (mod 16).
  - end is set to the slot just written.
- A bank completes when slot 15 is written, or when flush is asserted.
  - On completion: state[fbank] becomes FULL, fbank toggles, and wr_ptr is reset to 0.
  - A block never wraps past slot 15. A block starting at slot 12 completes after 4 accepts.
- Flush rules:
  - flush together with an accept: the sub-block is written first, then the bank closes.
  - flush while state[fbank] is EMPTY, with no accept: no-op.
  - flush while state[fbank] is FULL: ignored.
- Output side:
  - blk_valid = (state[obank] == FULL).
  - blko and the descriptor outputs are registered copies of bank obank, stable while blk_valid && !blk_ready.
  - On blk_valid && blk_ready: state[obank] becomes EMPTY and obank toggles.
  - need_full = (start == 0 && end == 15).
- Latency: the accept cycle that completes a block is cycle N. blk_valid is asserted at N+1, with blko updated in the same cycle.
- Same-cycle events:
  - A completion into one bank and a drain of the other bank are both honoured.
  - A drain of bank X frees it for fill in the following cycle, not the same cycle.
- Throughput:
  - Continuous blocks with blk_ready held at 1 sustain 1 sub-block per cycle.
  - With both banks FULL, sub_ready = 0 until a drain occurs.

Optional Feature:
- Macro: EACH_PANG_ZERO_FILL_EN.
- Defined: when a bank's first accept occurs, all 16 slot registers of that bank are cleared before the write. Unwritten slots of a partial block therefore read as 0 on blko.
- Undefined: unwritten slots keep stale data from the bank's previous use. The consumer relies only on the start/end descriptor.
- In both cases the descriptor outputs are identical.

Test Plan:
- Reset, then 16 accepts with start_sft = 0 and values 0x00..0x0F, blk_ready = 1:
  - blk_valid pulses one cycle after the 16th accept.
  - blko slot k = k; need_full = 1; start = 0; end = 15.
- start_sft = 12 and 4 accepts of 0xA0..0xA3:
  - slots 12..15 = 0xA0..0xA3; start = 12; end = 15; need_full = 0.
- start_sft = 3, accepts 0x11 and 0x22, then flush with no accept:
  - blk_valid next cycle with start = 3, end = 4.
  - With EACH_PANG_ZERO_FILL_EN defined, all other slots = 0.
- blk_ready = 0 and two full blocks pushed:
  - sub_ready drops after the 32nd accept; the 33rd sub_valid stalls.
  - blko holds block 1 stable.
  - Raising blk_ready for 1 cycle presents block 2 on the next cycle, and sub_ready returns to 1.
- reset asserted after 7 accepts:
  - next cycle: blk_valid = 0 and sub_ready = 1.
  - A new 16-accept block at start_sft = 0 is emitted correctly, with no residue of the partial block in the descriptor.

Source files
------------

// File: rtl/each_pang_to_blk_packer.sv
// Packs a sub-block stream into 16-slot blocks using ping/pang banks.
// Define EACH_PANG_ZERO_FILL_EN to clear a bank's slots on its first accept.
module each_pang_to_blk_packer #(
    parameter int SUB_BLK_BIT = 8,
    parameter int SFT_BIT     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SUB_BLK_BIT-1:0]    sub_blki,
    input  logic                      sub_valid,
    output logic                      sub_ready,
    input  logic [SFT_BIT-1:0]        start_sft,
    input  logic                      flush,
    output logic [16*SUB_BLK_BIT-1:0] blko,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic                      need_full,
    output logic [SFT_BIT-1:0]        need_pang_start_inc,
    output logic [SFT_BIT-1:0]        need_pang_end_inc
);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_FILLING = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;

    logic [1:0][1:0]                   r_state, w_state_nxt;
    logic [1:0][15:0][SUB_BLK_BIT-1:0] r_slot, w_slot_nxt;
    logic [1:0][SFT_BIT-1:0]           r_start, w_start_nxt;
    logic [1:0][SFT_BIT-1:0]           r_end, w_end_nxt;
    logic                              r_fbank, w_fbank_nxt;
    logic                              r_obank, w_obank_nxt;
    logic [SFT_BIT-1:0]                r_wr_ptr, w_wr_ptr_nxt, w_idx;
    logic                              w_accept, w_done, w_drain;

    logic [16*SUB_BLK_BIT-1:0]         r_blko;
    logic                              r_need_full;
    logic [SFT_BIT-1:0]                r_need_start, r_need_end;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= {S_EMPTY, S_EMPTY};
            r_start  <= '0;
            r_end    <= '0;
            r_fbank  <= 1'b0;
            r_obank  <= 1'b0;
            r_wr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_start  <= w_start_nxt;
            r_end    <= w_end_nxt;
            r_fbank  <= w_fbank_nxt;
            r_obank  <= w_obank_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
        end
    end

    // slot storage carries no reset; validity is tracked by the state
    always_ff @(posedge clk) begin
        r_slot <= w_slot_nxt;
    end

    // next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_slot_nxt   = r_slot;
        w_start_nxt  = r_start;
        w_end_nxt    = r_end;
        w_fbank_nxt  = r_fbank;
        w_obank_nxt  = r_obank;
        w_wr_ptr_nxt = r_wr_ptr;
        w_idx        = r_wr_ptr;
        w_done       = 1'b0;
        if (w_accept) begin
            if (r_state[r_fbank] == S_EMPTY) begin
                w_idx                = start_sft;
                w_start_nxt[r_fbank] = start_sft;
                w_state_nxt[r_fbank] = S_FILLING;
`ifdef EACH_PANG_ZERO_FILL_EN
                w_slot_nxt[r_fbank]  = '0;
`endif
            end
            w_slot_nxt[r_fbank][w_idx] = sub_blki;
            w_end_nxt[r_fbank]         = w_idx;
            w_wr_ptr_nxt               = w_idx + SFT_BIT'(1);
            w_done                     = (&w_idx) || flush;
        end else if (flush && r_state[r_fbank] == S_FILLING) begin
            w_done = 1'b1;
        end
        // a completing bank is never FULL, so it cannot be the drained one
        if (w_done) begin
            w_state_nxt[r_fbank] = S_FULL;
            w_fbank_nxt          = ~r_fbank;
            w_wr_ptr_nxt         = '0;
        end
        if (w_drain) begin
            w_state_nxt[r_obank] = S_EMPTY;
            w_obank_nxt          = ~r_obank;
        end
    end

    // output registers follow the bank that will be presented next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blko       <= '0;
            r_need_full  <= 1'b0;
            r_need_start <= '0;
            r_need_end   <= '0;
        end else begin
            r_blko       <= w_slot_nxt[w_obank_nxt];
            r_need_start <= w_start_nxt[w_obank_nxt];
            r_need_end   <= w_end_nxt[w_obank_nxt];
            r_need_full  <= (w_start_nxt[w_obank_nxt] == '0) &&
                            (&w_end_nxt[w_obank_nxt]);
        end
    end

    // output logic
    always_comb begin
        sub_ready = (r_state[r_fbank] != S_FULL);
        blk_valid = (r_state[r_obank] == S_FULL);
        w_accept  = sub_valid && sub_ready;
        w_drain   = blk_valid && blk_ready;
    end

    assign blko                = r_blko;
    assign need_full           = r_need_full;
    assign need_pang_start_inc = r_need_start;
    assign need_pang_end_inc   = r_need_end;

endmodule
